// File: rtl/sdram_request_queue_if.sv
// Host request/response and controller command signals of sdram_request_queue.
// slave: the queue itself; master: the host and controller it sits between.
interface sdram_request_queue_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 16
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0]    req_data;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_data;
  logic                     write_complete;
  logic [1:0]               command;
  logic [ADDRESS_WIDTH-1:0] data_address;
  logic [DATA_WIDTH-1:0]    data_write;
  logic [DATA_WIDTH-1:0]    data_read;
  logic                     data_read_valid;
  logic                     data_write_done;
  logic                     busy;
  logic                     error;

  modport slave (
    input  req_valid, req_write, req_address, req_data,
    input  data_read, data_read_valid, data_write_done,
    output req_ready, resp_valid, resp_data, write_complete,
    output command, data_address, data_write, busy, error
  );

  modport master (
    output req_valid, req_write, req_address, req_data,
    output data_read, data_read_valid, data_write_done,
    input  req_ready, resp_valid, resp_data, write_complete,
    input  command, data_address, data_write, busy, error
  );
endinterface

// File: rtl/sdram_request_queue.sv
// Buffers host requests in a FIFO and issues them one at a time to the as4c4m16sa controller.
// Optional command watchdog enabled by defining SDRAM_REQUEST_QUEUE_TIMEOUT_EN.
module sdram_request_queue #(
  parameter int DEPTH          = 4,
  parameter int ADDRESS_WIDTH  = 22,
  parameter int DATA_WIDTH     = 16,
  parameter int RELEASE_CYCLES = 2,
  parameter int TIMEOUT        = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_request_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);
  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

  entry_t                   mem_q [DEPTH];
  logic [PW:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t                   state_q, state_d;
  logic [RW-1:0]            rel_cnt_q, rel_cnt_d;
  logic [1:0]               command_q, command_d;
  logic [ADDRESS_WIDTH-1:0] data_address_q, data_address_d;
  logic [DATA_WIDTH-1:0]    data_write_q, data_write_d;
  logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     write_complete_q, write_complete_d;
  logic                     error_q, error_d;
  logic                     empty, full, push, pop;
  entry_t                   head, push_entry;

`ifdef SDRAM_REQUEST_QUEUE_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
`endif

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push       = bus.req_valid && !full;
  assign pop        = (state_q == S_IDLE) && !empty;
  assign head       = mem_q[rd_ptr_q[PW-1:0]];
  assign push_entry = {bus.req_write, bus.req_address, bus.req_data};

  always_comb begin
    wr_ptr_d         = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d         = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    state_d          = state_q;
    rel_cnt_d        = rel_cnt_q;
    command_d        = command_q;
    data_address_d   = data_address_q;
    data_write_d     = data_write_q;
    resp_data_d      = resp_data_q;
    resp_valid_d     = 1'b0;
    write_complete_d = 1'b0;
    error_d          = error_q;
`ifdef SDRAM_REQUEST_QUEUE_TIMEOUT_EN
    wd_cnt_d         = wd_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          command_d      = head.write ? CMD_WRITE : CMD_READ;
          data_address_d = head.address;
          data_write_d   = head.data;
          state_d        = S_WAIT;
`ifdef SDRAM_REQUEST_QUEUE_TIMEOUT_EN
          wd_cnt_d       = '0;
`endif
        end
      end
      // Only the acknowledge that matches the pending command is honoured.
      S_WAIT: begin
        if (command_q == CMD_WRITE && bus.data_write_done) begin
          write_complete_d = 1'b1;
          command_d        = CMD_IDLE;
          rel_cnt_d        = '0;
          state_d          = S_RELEASE;
        end else if (command_q == CMD_READ && bus.data_read_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = bus.data_read;
          command_d    = CMD_IDLE;
          rel_cnt_d    = '0;
          state_d      = S_RELEASE;
        end
`ifdef SDRAM_REQUEST_QUEUE_TIMEOUT_EN
        else if (TIMEOUT > 0 && wd_cnt_q == WD_LAST) begin
          error_d   = 1'b1;
          command_d = CMD_IDLE;
          rel_cnt_d = '0;
          state_d   = S_RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (rel_cnt_q == REL_LAST) state_d = S_IDLE;
        else rel_cnt_d = rel_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      state_q          <= S_IDLE;
      rel_cnt_q        <= '0;
      command_q        <= CMD_IDLE;
      data_address_q   <= '0;
      data_write_q     <= '0;
      resp_data_q      <= '0;
      resp_valid_q     <= 1'b0;
      write_complete_q <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      state_q          <= state_d;
      rel_cnt_q        <= rel_cnt_d;
      command_q        <= command_d;
      data_address_q   <= data_address_d;
      data_write_q     <= data_write_d;
      resp_data_q      <= resp_data_d;
      resp_valid_q     <= resp_valid_d;
      write_complete_q <= write_complete_d;
      error_q          <= error_d;
    end
  end

`ifdef SDRAM_REQUEST_QUEUE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) wd_cnt_q <= '0;
    else       wd_cnt_q <= wd_cnt_d;
  end
`endif

  // Storage needs no reset: entries are only read behind the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_entry;
  end

  assign bus.req_ready      = !full;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_data      = resp_data_q;
  assign bus.write_complete = write_complete_q;
  assign bus.command        = command_q;
  assign bus.data_address   = data_address_q;
  assign bus.data_write     = data_write_q;
  assign bus.busy           = !empty || (state_q != S_IDLE);
  // A TIMEOUT of 0 disables the watchdog flag.
  assign bus.error          = error_q && (TIMEOUT > 0);
endmodule

// File: tb/tb_sdram_request_queue.sv
// Directed plus randomized bench for sdram_request_queue with a host/controller reference model.
module tb_sdram_request_queue;
  localparam int AW = 22, DW = 16, DEPTH = 4, RC = 2, TO = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0, n_bad = 0;

  sdram_request_queue_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  sdram_request_queue #(
    .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .RELEASE_CYCLES(RC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t          issue_q[$];
  req_t          done_q[$];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] sdram[logic [AW-1:0]];
  req_t          cur;
  bit            cur_vld, acked, ctrl_stall, rand_delay, inject_wrong;
  int            ack_delay, cmd_ticks, wc_seen, rv_seen;

  function automatic logic [DW-1:0] pattern(logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hA5C3;
  endfunction

  function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs after the edge, update the model, drive the controller side.
  task automatic tick();
    req_t r;
    @(posedge clk);
    #1;
    bus.data_write_done = 1'b0;
    bus.data_read_valid = 1'b0;
    bus.data_read       = DW'($urandom);
    if (bus.write_complete === 1'b1) begin
      wc_seen++;
      if (done_q.size() == 0) check("wc_spurious", bus.write_complete, 0);
      else begin
        r = done_q.pop_front();
        check("wc_kind", 64'(r.wr), 1);
        if (r.wr) ref_mem[r.addr] = r.data;
      end
    end
    if (bus.resp_valid === 1'b1) begin
      rv_seen++;
      if (done_q.size() == 0) check("rv_spurious", bus.resp_valid, 0);
      else begin
        r = done_q.pop_front();
        check("rv_kind", 64'(r.wr), 0);
        check("resp_data", bus.resp_data, ref_read(r.addr));
      end
    end
    if (bus.command !== 2'd0) begin
      if (!cur_vld) begin
        cur_vld   = 1'b1;
        acked     = 1'b0;
        cmd_ticks = 0;
        if (rand_delay) ack_delay = $urandom_range(0, 4);
        if (issue_q.size() == 0) check("cmd_spurious", bus.command, 0);
        else begin
          cur = issue_q.pop_front();
          done_q.push_back(cur);
          check("cmd_issue", {bus.command, bus.data_address}, {(cur.wr ? 2'd1 : 2'd2), cur.addr});
          if (cur.wr) check("cmd_wdata", bus.data_write, cur.data);
        end
      end else begin
        check("cmd_hold", {bus.command, bus.data_address}, {(cur.wr ? 2'd1 : 2'd2), cur.addr});
      end
      cmd_ticks++;
      if (!ctrl_stall && !acked) begin
        if (inject_wrong && cmd_ticks == 2) begin
          inject_wrong = 1'b0;
          if (cur.wr) bus.data_read_valid = 1'b1;
          else        bus.data_write_done = 1'b1;
        end else if (cmd_ticks > ack_delay) begin
          acked = 1'b1;
          if (cur.wr) begin
            sdram[bus.data_address] = bus.data_write;
            bus.data_write_done     = 1'b1;
          end else begin
            bus.data_read       = sdram.exists(bus.data_address) ? sdram[bus.data_address]
                                                                 : pattern(bus.data_address);
            bus.data_read_valid = 1'b1;
          end
        end
      end
    end else begin
      cur_vld = 1'b0;
    end
  endtask

  task automatic push(bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    int   budget = 500;
    req_t r;
    check("req_ready_model", bus.req_ready, 64'(issue_q.size() < DEPTH));
    bus.req_valid   = 1'b1;
    bus.req_write   = wr;
    bus.req_address = a;
    bus.req_data    = d;
    while (bus.req_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    check("push_accept", bus.req_ready, 1);
    r = '{wr: wr, addr: a, data: d};
    issue_q.push_back(r);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(string tag, int n_wc, int n_rv);
    int budget = 300;
    while ((wc_seen < n_wc || rv_seen < n_rv) && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 64'(wc_seen >= n_wc && rv_seen >= n_rv), 1);
  endtask

  task automatic wait_idle(string tag);
    int budget = 3000;
    while ((issue_q.size() != 0 || done_q.size() != 0 || cur_vld || bus.busy !== 1'b0) && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 64'(issue_q.size() == 0 && done_q.size() == 0 && bus.busy === 1'b0), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int wc0, rv0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_address = '0; bus.req_data = '0;
    bus.data_read = '0; bus.data_read_valid = 1'b0; bus.data_write_done = 1'b0;
    cur_vld = 0; acked = 0; ctrl_stall = 0; rand_delay = 0; inject_wrong = 0;
    ack_delay = 0; cmd_ticks = 0; wc_seen = 0; rv_seen = 0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_command", bus.command, 0);
    check("rst_address", bus.data_address, 0);
    check("rst_wdata", bus.data_write, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_wc", bus.write_complete, 0);
    check("rst_error", bus.error, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.req_ready, 1);
    reset = 1'b0;
    tick();

    // Single write, acknowledged after a fixed delay
    ack_delay = 5;
    wc0 = wc_seen;
    push(1'b1, 22'h000010, 16'hFACE);
    wait_done("w_done", wc0 + 1, rv_seen);
    check("w_held_cycles", cmd_ticks, ack_delay + 1);
    check("w_rel1_cmd", bus.command, 0);
    tick();
    check("w_rel2_cmd", bus.command, 0);
    check("w_wc_single", bus.write_complete, 0);
    tick();
    check("w_idle_busy", bus.busy, 0);
    check("w_wc_count", wc_seen, wc0 + 1);

    // Read back the same word
    ack_delay = 3;
    rv0 = rv_seen;
    push(1'b0, 22'h000010, 16'h0000);
    wait_done("r_done", wc_seen, rv0 + 1);
    check("r_data_face", bus.resp_data, 16'hFACE);
    tick();
    check("r_strobe_single", bus.resp_valid, 0);
    wait_idle("r_idle");

    // Back-to-back pushes against a stalled controller
    ctrl_stall = 1'b1;
    wc0 = wc_seen; rv0 = rv_seen;
    for (int i = 0; i < 5; i++) push((i % 2) == 0, AW'(22'h100 + i), DW'($urandom));
    check("full_ready", bus.req_ready, 0);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_address = 22'h3FFFFF;
    repeat (3) tick();
    bus.req_valid = 1'b0;
    ctrl_stall = 1'b0;
    rand_delay = 1'b1;
    wait_idle("fill_idle");
    check("fill_writes", wc_seen - wc0, 3);
    check("fill_reads", rv_seen - rv0, 2);

    // Reset while a command is pending and three are queued
    ctrl_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, AW'(22'h200 + i), DW'($urandom));
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_cmd", bus.command, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    reset = 1'b0;
    issue_q.delete();
    done_q.delete();
    cur_vld = 1'b0;
    ctrl_stall = 1'b0;
    wc0 = wc_seen; rv0 = rv_seen;
    repeat (6) tick();
    check("post_rst_no_wc", wc_seen, wc0);
    check("post_rst_no_rv", rv_seen, rv0);
    check("post_rst_cmd", bus.command, 0);
    push(1'b1, 22'h000222, 16'hBEEF);
    wait_idle("post_rst_idle");
    check("post_rst_wc", wc_seen - wc0, 1);

    // Acknowledge of the wrong kind must be ignored
    rand_delay = 1'b0;
    ack_delay = 6;
    wc0 = wc_seen; rv0 = rv_seen;
    inject_wrong = 1'b1;
    push(1'b1, 22'h000020, 16'h1234);
    wait_done("wrong_w_done", wc0 + 1, rv0);
    check("wrong_w_held", cmd_ticks, ack_delay + 1);
    check("wrong_w_no_rv", rv_seen, rv0);
    inject_wrong = 1'b1;
    push(1'b0, 22'h000020, 16'h0000);
    wait_done("wrong_r_done", wc0 + 1, rv0 + 1);
    check("wrong_r_held", cmd_ticks, ack_delay + 1);
    check("wrong_r_no_wc", wc_seen, wc0 + 1);
    wait_idle("wrong_idle");

    // Random traffic over a small address set
    rand_delay = 1'b1;
    wc0 = wc_seen; rv0 = rv_seen;
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rand_idle");
    check("rand_count", (wc_seen - wc0) + (rv_seen - rv0), 40);

`ifdef SDRAM_REQUEST_QUEUE_TIMEOUT_EN
    begin
      int budget = 100;
      ctrl_stall = 1'b1;
      wc0 = wc_seen; rv0 = rv_seen;
      push(1'b1, 22'h000030, 16'h5555);
      push(1'b0, 22'h000030, 16'h0000);
      while (bus.error !== 1'b1 && budget > 0) begin
        tick();
        budget--;
      end
      check("to_error", bus.error, 1);
      check("to_cycles", cmd_ticks, TO);
      check("to_cmd", bus.command, 0);
      check("to_no_strobe", (wc_seen - wc0) + (rv_seen - rv0), 0);
      if (done_q.size() != 0) void'(done_q.pop_front());
      ctrl_stall = 1'b0;
      wait_idle("to_idle");
      check("to_next_read", rv_seen - rv0, 1);
      check("to_sticky", bus.error, 1);
    end
`else
    check("error_tied", bus.error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
